dpu: RTL and testbench

- 8-bit datapath unit for the Turbo_GRAFIX line/point rasteriser.
- Contains a 16-entry register file, a small ALU with condition codes, and an immediate-load path.
- The command control unit drives it every cycle with register selectors (A, B, R), an opcode and an immediate byte.
- It presents the current pixel as {X, Y, Colour} on Kbus.

---
 rtl/dpu.sv | 111 +++++++++++
 tb/tb_dpu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dpu.sv
// dpu: 8-bit datapath for the Turbo_GRAFIX line/point rasteriser.
// 16-entry register file (12 = const 1, 13 = const 0), ALU with {N,Z,C,V}
// condition codes and an immediate-load path. Kbus shows {X, Y, Colour}.
module dpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Abus,
  input  logic [3:0]  Bbus,
  input  logic [3:0]  Rbus,
  input  logic [3:0]  n,
  output logic [3:0]  cc,
  output logic [23:0] Kbus,
  input  logic [7:0]  mData
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SHL  = 4'd2,
    OP_SHR  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_CMP  = 4'd6,
    OP_MOV  = 4'd7,
    OP_LOAD = 4'd8
  } op_e;

  localparam logic [3:0] REG_ONE  = 4'd12;
  localparam logic [3:0] REG_ZERO = 4'd13;

  logic [7:0] rf [16];
  logic [7:0] a, b, res;
  logic [8:0] sum9, diff9;
  logic       c, v, wr_en, fl_en;

  // Operand A read; constant registers bypass the storage array
  always_comb begin
    a = rf[Abus];
    if (Abus == REG_ONE)       a = 8'd1;
    else if (Abus == REG_ZERO) a = '0;
  end

  // Operand B read; constant registers bypass the storage array
  always_comb begin
    b = rf[Bbus];
    if (Bbus == REG_ONE)       b = 8'd1;
    else if (Bbus == REG_ZERO) b = '0;
  end

  assign sum9  = {1'b0, a} + {1'b0, b};
  assign diff9 = {1'b0, a} - {1'b0, b};

  // ALU: result, carry/overflow, and which state the opcode is allowed to touch
  always_comb begin
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    wr_en = 1'b1;
    fl_en = 1'b1;
    case (n)
      OP_ADD: begin
        res = sum9[7:0];
        c   = sum9[8];
        v   = (a[7] == b[7]) && (res[7] != a[7]);
      end
      OP_SUB, OP_CMP: begin
        res = diff9[7:0];
        c   = diff9[8];
        v   = (a[7] != b[7]) && (res[7] != a[7]);
      end
      OP_SHL: begin
        res = {a[6:0], 1'b0};
        c   = a[7];
        v   = a[7] ^ a[6];
      end
      OP_SHR: begin
        res = {a[7], a[7:1]};
        c   = a[0];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_MOV:  res = a;
      OP_LOAD: begin
        res   = mData;
        fl_en = 1'b0;
      end
      default: begin
        wr_en = 1'b0;
        fl_en = 1'b0;
      end
    endcase
  end

  // Register file write; destinations 12/13 are silently dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wr_en && (Rbus != REG_ONE) && (Rbus != REG_ZERO)) begin
      rf[Rbus] <= res;
    end
  end

  // Condition codes {N, Z, C, V}, held across LOAD and NOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cc <= '0;
    else if (fl_en) cc <= {res[7], (res == 8'd0), c, v};
  end

  assign Kbus = {rf[9], rf[10], rf[11]};

endmodule

// File: tb/tb_dpu.sv
// tb_dpu: directed vector table, hand sequences and randomized ops
// checked against an arithmetic reference model of the dpu.
module tb_dpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  Abus = '0, Bbus = '0, Rbus = '0, n = 4'd9;
  logic [7:0]  mData = '0;
  logic [3:0]  cc;
  logic [23:0] Kbus;

  int checks = 0;
  int failures = 0;

  dpu u_dpu (
    .clk(clk), .rst(rst), .Abus(Abus), .Bbus(Bbus), .Rbus(Rbus),
    .n(n), .cc(cc), .Kbus(Kbus), .mData(mData)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m [16];
  logic [3:0] mcc;

  function automatic int rd(int i);
    if (i == 12) return 1;
    if (i == 13) return 0;
    return m[i];
  endfunction

  function automatic int sgn(int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic bit ovf(int s);
    return (s > 127) || (s < -128);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 0;
    mcc = '0;
  endtask

  task automatic model_op(int ai, int bi, int ri, int op, int d);
    int A, B, res, sa;
    bit C, V;
    A = rd(ai); B = rd(bi); C = 0; V = 0; res = 0;
    if (op == 8) begin
      if (ri != 12 && ri != 13) m[ri] = d;
      return;
    end
    if (op > 8) return;
    case (op)
      0: begin res = (A + B) % 256; C = (A + B) > 255; V = ovf(sgn(A) + sgn(B)); end
      1, 6: begin res = (A - B + 256) % 256; C = A < B; V = ovf(sgn(A) - sgn(B)); end
      2: begin res = (A * 2) % 256; C = A >= 128; V = ovf(sgn(A) * 2); end
      3: begin
        sa = sgn(A);
        sa = (sa >= 0) ? sa / 2 : -((1 - sa) / 2);
        res = (sa + 256) % 256; C = (A % 2) == 1;
      end
      4: res = A & B;
      5: res = A | B;
      default: res = A;
    endcase
    if (ri != 12 && ri != 13) m[ri] = res;
    mcc = {res >= 128, res == 0, C, V};
  endtask

  function automatic logic [23:0] model_k();
    logic [7:0] x, y, col;
    x = m[9][7:0]; y = m[10][7:0]; col = m[11][7:0];
    return {x, y, col};
  endfunction

  task automatic chk(string name, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op, clock it, update the model, sample 1ns after the edge
  task automatic step(int ai, int bi, int ri, int op, int d);
    Abus = ai[3:0]; Bbus = bi[3:0]; Rbus = ri[3:0]; n = op[3:0]; mData = d[7:0];
    @(posedge clk);
    model_op(ai, bi, ri, op, d);
    #1;
  endtask

  // Asynchronous reset pulse landing between clock edges
  task automatic async_reset(string name);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({name, "_cc"}, {20'd0, cc}, 24'd0);
    chk({name, "_kbus"}, Kbus, 24'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic readout(string name, int r, int exp);
    step(r, 13, 11, 7, 0);
    chk(name, {16'd0, Kbus[7:0]}, exp[23:0]);
  endtask

  typedef struct {
    logic [3:0]  a, b, r, op;
    logic [7:0]  d;
    logic [3:0]  ecc;
    logic [23:0] ek;
  } vec_t;

  vec_t tv [18];

  initial begin
    tv[0]  = '{4'd0,  4'd0,  4'd9,  4'd8, 8'h12, 4'b0000, 24'h120000};
    tv[1]  = '{4'd0,  4'd0,  4'd10, 4'd8, 8'h34, 4'b0000, 24'h123400};
    tv[2]  = '{4'd0,  4'd0,  4'd11, 4'd8, 8'h56, 4'b0000, 24'h123456};
    tv[3]  = '{4'd0,  4'd0,  4'd15, 4'd8, 8'hFF, 4'b0000, 24'h123456};
    tv[4]  = '{4'd15, 4'd12, 4'd11, 4'd0, 8'h00, 4'b0110, 24'h123400};
    tv[5]  = '{4'd0,  4'd0,  4'd15, 4'd8, 8'h7F, 4'b0110, 24'h123400};
    tv[6]  = '{4'd15, 4'd12, 4'd11, 4'd0, 8'h00, 4'b1001, 24'h123480};
    tv[7]  = '{4'd0,  4'd0,  4'd14, 4'd8, 8'h80, 4'b1001, 24'h123480};
    tv[8]  = '{4'd14, 4'd0,  4'd11, 4'd2, 8'h00, 4'b0111, 24'h123400};
    tv[9]  = '{4'd15, 4'd12, 4'd12, 4'd0, 8'h00, 4'b1001, 24'h123400};
    tv[10] = '{4'd13, 4'd0,  4'd9,  4'd9, 8'h00, 4'b1001, 24'h123400};
    tv[11] = '{4'd13, 4'd13, 4'd10, 4'd15, 8'h00, 4'b1001, 24'h123400};
    tv[12] = '{4'd12, 4'd0,  4'd11, 4'd7, 8'h00, 4'b0000, 24'h123401};
    tv[13] = '{4'd13, 4'd0,  4'd9,  4'd7, 8'h00, 4'b0100, 24'h003401};
    tv[14] = '{4'd14, 4'd0,  4'd10, 4'd3, 8'h00, 4'b1000, 24'h00C001};
    tv[15] = '{4'd15, 4'd14, 4'd11, 4'd4, 8'h00, 4'b0100, 24'h00C000};
    tv[16] = '{4'd15, 4'd14, 4'd11, 4'd5, 8'h00, 4'b1000, 24'h00C0FF};
    tv[17] = '{4'd13, 4'd12, 4'd11, 4'd1, 8'h00, 4'b1010, 24'h00C0FF};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cc", {20'd0, cc}, 24'd0);
    chk("reset_kbus", Kbus, 24'd0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      step(tv[i].a, tv[i].b, tv[i].r, tv[i].op, tv[i].d);
      chk($sformatf("vec%0d_cc", i), {20'd0, cc}, {20'd0, tv[i].ecc});
      chk($sformatf("vec%0d_kbus", i), Kbus, tv[i].ek);
    end

    // Mid-run reset, then pixel bus reload
    async_reset("midreset");
    step(0, 0, 9, 8, 8'h12);
    step(0, 0, 10, 8, 8'h34);
    step(0, 0, 11, 8, 8'h56);
    chk("pixel_kbus", Kbus, 24'h123456);

    // Bresenham init
    step(0, 0, 5, 8, 2);
    step(0, 0, 7, 8, 3);
    step(0, 0, 6, 8, 10);
    step(0, 0, 8, 8, 7);
    step(8, 7, 1, 1, 0);
    step(6, 5, 0, 1, 0);
    step(1, 0, 4, 2, 0);
    step(4, 0, 2, 1, 0);
    chk("bres_sub2_cc", {20'd0, cc}, 24'h000004);
    step(2, 0, 3, 1, 0);
    chk("bres_final_cc", {20'd0, cc}, 24'h00000A);
    readout("bres_dy", 1, 4);
    readout("bres_dx", 0, 8);
    readout("bres_2dy", 4, 8);
    readout("bres_err", 2, 0);
    readout("bres_einc", 3, 8'hF8);

    // Compare sign test on Error
    step(0, 0, 2, 8, 8'hFD);
    step(2, 13, 14, 6, 0);
    chk("cmp_neg_cc", {20'd0, cc}, 24'h000008);
    step(0, 0, 2, 8, 0);
    step(2, 13, 14, 6, 0);
    chk("cmp_zero_cc", {20'd0, cc}, 24'h000004);

    // Self-increment of X held for three edges
    step(0, 0, 9, 8, 5);
    for (int k = 0; k < 3; k++) begin
      step(9, 12, 9, 0, 0);
      chk($sformatf("inc%0d_x", k), {16'd0, Kbus[23:16]}, 24'(6 + k));
    end

    // Randomized ops with occasional async resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) async_reset("rnd_reset");
      step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 255));
      chk($sformatf("rnd%0d_cc", i), {20'd0, cc}, {20'd0, mcc});
      chk($sformatf("rnd%0d_kbus", i), Kbus, model_k());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
